// File: rtl/router_reg_p_if.sv
// Bus bundle between the router FSM/source side and the register stage.
// The master side drives the FSM state strobes and the source byte; the
// slave side (the register stage) returns the FIFO byte and check results.
interface router_reg_p_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();
  logic              pkt_valid;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              len_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, data_in,
    input  dout, parity_done, low_pkt_valid, err, len_err, err_cnt
  );

  modport slave (
    input  pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, data_in,
    output dout, parity_done, low_pkt_valid, err, len_err, err_cnt
  );
endinterface

// File: rtl/router_reg_p.sv
// Router register stage: latches the header, forwards header/payload/parity
// bytes to the FIFO, parks the byte that arrives while the FIFO is full,
// and checks XOR parity and payload length once the parity byte is in.
module router_reg_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int LEN_W    = 6,
  parameter int NUM_DEST = 3,
  parameter int CHK_MODE = 1,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  router_reg_p_if.slave bus
);

  // Payload counter has one extra bit so a full-length packet plus a stray
  // byte still shows up as a length mismatch instead of wrapping to match.
  localparam int PC_W = LEN_W + 1;

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] int_par_q, int_par_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [PC_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic              parity_done_q, parity_done_d;
  logic              chk_done_q, chk_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;
  logic              len_err_q, len_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [ADDR_W-1:0] addr_field;
  logic [LEN_W-1:0]  len_field;
  logic              addr_ok;
  logic              hdr_latch;
  logic              par_mis;
  logic              len_mis;

  assign addr_field = bus.data_in[ADDR_W-1:0];
  assign len_field  = hdr_q[ADDR_W+LEN_W-1:ADDR_W];
  assign addr_ok    = (32'(addr_field) < $unsigned(NUM_DEST));
  assign hdr_latch  = bus.detect_add & bus.pkt_valid & addr_ok;
  assign par_mis    = (int_par_q != pkt_par_q);
  assign len_mis    = (CHK_MODE != 0) && (pay_cnt_q != {1'b0, len_field});

  // Next-state for the datapath, parity/length check and error counter.
  // Later assignments deliberately override earlier ones (header latch last).
  always_comb begin
    hdr_d           = hdr_q;
    hold_d          = hold_q;
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    dout_d          = dout_q;
    pay_cnt_d       = pay_cnt_q;
    parity_done_d   = parity_done_q;
    chk_done_d      = chk_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;
    len_err_d       = len_err_q;
    err_cnt_d       = err_cnt_q;

    // One-shot check on the edge after the parity byte is captured.
    if (parity_done_q && !chk_done_q) begin
      err_d      = par_mis;
      len_err_d  = len_mis;
      chk_done_d = 1'b1;
      if ((par_mis || len_mis) && (err_cnt_q != {CNT_W{1'b1}}))
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    // FIFO byte selection; header contributes to parity when forwarded.
    if (bus.lfd_state) begin
      dout_d    = hdr_q;
      int_par_d = int_par_q ^ hdr_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (bus.ld_state && bus.fifo_full) begin
      hold_d = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = hold_q;
    end

    // Payload bytes are counted once, when first accepted in ld_state.
    if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
      int_par_d = int_par_q ^ bus.data_in;
      if (pay_cnt_q != {PC_W{1'b1}})
        pay_cnt_d = pay_cnt_q + PC_W'(1);
    end

    // Parity byte arrives either directly or out of the hold register.
    if (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) begin
      pkt_par_d     = bus.data_in;
      parity_done_d = 1'b1;
    end else if (bus.laf_state && low_pkt_valid_q && !parity_done_q) begin
      pkt_par_d     = hold_q;
      parity_done_d = 1'b1;
    end

    // Set has priority over the FSM's clear.
    if (bus.ld_state && !bus.pkt_valid)
      low_pkt_valid_d = 1'b1;
    else if (bus.rst_int_reg)
      low_pkt_valid_d = 1'b0;

    // A valid header starts a fresh packet; bad addresses are ignored.
    if (hdr_latch) begin
      hdr_d         = bus.data_in;
      int_par_d     = '0;
      pay_cnt_d     = '0;
      parity_done_d = 1'b0;
      chk_done_d    = 1'b0;
      err_d         = 1'b0;
      len_err_d     = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q           <= '0;
      hold_q          <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      dout_q          <= '0;
      pay_cnt_q       <= '0;
      parity_done_q   <= 1'b0;
      chk_done_q      <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      len_err_q       <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      dout_q          <= dout_d;
      pay_cnt_q       <= pay_cnt_d;
      parity_done_q   <= parity_done_d;
      chk_done_q      <= chk_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
      len_err_q       <= len_err_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;
  assign bus.len_err       = len_err_q;
  assign bus.err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_router_reg_p.sv
// Bench for router_reg_p: directed packets driven through the FSM strobes,
// a packet-level reference model, and a per-cycle output comparison.
module tb_router_reg_p;
  localparam int CHK_MODE = 1;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_reg_p_if #(.DATA_W(8), .CNT_W(CNT_W)) bus ();

  router_reg_p #(
    .DATA_W(8), .ADDR_W(2), .LEN_W(6), .NUM_DEST(3),
    .CHK_MODE(CHK_MODE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the list of bytes that contribute to parity and the payload count;
  // parity is recomputed from the whole list when the check fires.
  logic [7:0] m_hdr, m_hold, m_dout, m_par;
  logic [7:0] m_x[$];
  int  m_npay, m_cnt;
  bit  m_done, m_chk, m_low, m_err, m_lerr;
  bit  o_done, o_low;
  logic [7:0] xr;
  int  len_sat;

  always @(posedge clk) begin
    if (rst) begin
      m_hdr = 0; m_hold = 0; m_dout = 0; m_par = 0; m_x.delete(); m_npay = 0;
      m_cnt = 0; m_done = 0; m_chk = 0; m_low = 0; m_err = 0; m_lerr = 0;
    end else begin
      o_done = m_done;
      o_low  = m_low;
      if (m_done && !m_chk) begin
        xr = 8'h00;
        foreach (m_x[k]) xr = xr ^ m_x[k];
        len_sat = (m_npay > 127) ? 127 : m_npay;
        m_err  = (xr != m_par);
        m_lerr = (CHK_MODE != 0) && (len_sat != int'(m_hdr[7:2]));
        if ((m_err || m_lerr) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        m_chk = 1;
      end
      if (bus.lfd_state) begin
        m_dout = m_hdr; m_x.push_back(m_hdr);
      end else if (bus.ld_state && !bus.fifo_full) m_dout = bus.data_in;
      else if (bus.ld_state && bus.fifo_full) m_hold = bus.data_in;
      else if (bus.laf_state) m_dout = m_hold;
      if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
        m_x.push_back(bus.data_in); m_npay++;
      end
      if (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) begin
        m_par = bus.data_in; m_done = 1;
      end else if (bus.laf_state && o_low && !o_done) begin
        m_par = m_hold; m_done = 1;
      end
      if (bus.ld_state && !bus.pkt_valid) m_low = 1;
      else if (bus.rst_int_reg) m_low = 0;
      if (bus.detect_add && bus.pkt_valid && bus.data_in[1:0] < 2'd3) begin
        m_hdr = bus.data_in; m_x.delete(); m_npay = 0;
        m_done = 0; m_chk = 0; m_err = 0; m_lerr = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dout", 32'(bus.dout), 32'(m_dout));
      chk("parity_done", 32'(bus.parity_done), 32'(m_done));
      chk("low_pkt_valid", 32'(bus.low_pkt_valid), 32'(m_low));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("len_err", 32'(bus.len_err), 32'(m_lerr));
      chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pl[0:9];

  task automatic step(input logic da, lfd, ld, laf, fs, pv, ff, rir, input logic [7:0] d);
    bus.detect_add = da; bus.lfd_state = lfd; bus.ld_state = ld; bus.laf_state = laf;
    bus.full_state = fs; bus.pkt_valid = pv; bus.fifo_full = ff; bus.rst_int_reg = rir;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // full_idx: payload index that meets a full FIFO (n means the parity byte), -1 for none.
  task automatic send_pkt(input logic [7:0] hdr, input int n, input bit bad, input int full_idx);
    logic [7:0] p;
    p = hdr;
    step(1, 0, 0, 0, 0, 1, 0, 0, hdr);
    step(0, 1, 0, 0, 0, 1, 0, 0, pl[0]);
    for (int i = 0; i < n; i++) begin
      p = p ^ pl[i];
      if (i == full_idx) begin
        step(0, 0, 1, 0, 0, 1, 1, 0, pl[i]);
        step(0, 0, 0, 0, 1, 1, 0, 0, pl[i]);
        step(0, 0, 0, 1, 0, 1, 0, 0, pl[i]);
        chk("laf_dout", 32'(bus.dout), 32'(pl[i]));
      end else begin
        step(0, 0, 1, 0, 0, 1, 0, 0, pl[i]);
      end
    end
    if (bad) p = ~p;
    if (full_idx == n) begin
      step(0, 0, 1, 0, 0, 0, 1, 0, p);
      step(0, 0, 0, 0, 1, 0, 0, 0, p);
      step(0, 0, 0, 1, 0, 0, 0, 0, p);
    end else begin
      step(0, 0, 1, 0, 0, 0, 0, 0, p);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle();
  endtask

  initial begin
    pl = '{8'h3C, 8'h91, 8'h5E, 8'hA5, 8'h07, 8'hD2, 8'h68, 8'hF1, 8'h00, 8'h00};
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.pkt_valid = 0; bus.fifo_full = 0; bus.rst_int_reg = 0;
    bus.data_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1;
    rst = 0;

    // 1: reset in the middle of a packet
    step(1, 0, 0, 0, 0, 1, 0, 0, 8'h22);
    step(0, 1, 0, 0, 0, 1, 0, 0, pl[0]);
    step(0, 0, 1, 0, 0, 1, 0, 0, pl[0]);
    step(0, 0, 1, 0, 0, 0, 0, 0, pl[1]);
    rst = 1;
    idle();
    idle();
    rst = 0;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_pdone", 32'(bus.parity_done), 32'h0);
    chk("rst_low", 32'(bus.low_pkt_valid), 32'h0);
    chk("rst_cnt", 32'(bus.err_cnt), 32'h0);

    // 2: good packet, header 8'h22 (len 8, dest 2)
    send_pkt(8'h22, 8, 0, -1);
    chk("t2_pdone", 32'(bus.parity_done), 32'h1);
    chk("t2_err", 32'(bus.err), 32'h0);
    chk("t2_len", 32'(bus.len_err), 32'h0);
    chk("t2_cnt", 32'(bus.err_cnt), 32'h0);

    // 3: bad parity, then a good packet
    send_pkt(8'h22, 8, 1, -1);
    chk("t3_err", 32'(bus.err), 32'h1);
    chk("t3_cnt", 32'(bus.err_cnt), 32'h1);
    send_pkt(8'h22, 8, 0, -1);
    chk("t3_err_clr", 32'(bus.err), 32'h0);
    chk("t3_cnt_hold", 32'(bus.err_cnt), 32'h1);

    // 4: FIFO full on payload byte A5, then on the parity byte
    send_pkt(8'h22, 8, 0, 3);
    chk("t4_err", 32'(bus.err), 32'h0);
    send_pkt(8'h22, 8, 0, 8);
    chk("t4b_err", 32'(bus.err), 32'h0);
    chk("t4b_pdone", 32'(bus.parity_done), 32'h1);

    // 5: short packet, 6 of 8 bytes
    send_pkt(8'h22, 6, 0, -1);
    chk("t5_len", 32'(bus.len_err), 32'h1);
    chk("t5_err", 32'(bus.err), 32'h0);
    chk("t5_cnt", 32'(bus.err_cnt), 32'h2);

    // 6: invalid destination is ignored
    step(1, 0, 0, 0, 0, 1, 0, 0, 8'h23);
    step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("t6_dout_hdr", 32'(bus.dout), 32'h22);
    idle();
    rst = 1;
    idle();
    rst = 0;

    // zero-length packet is legal
    send_pkt(8'h01, 0, 0, -1);
    chk("zl_len", 32'(bus.len_err), 32'h0);
    chk("zl_err", 32'(bus.err), 32'h0);

    // counter saturation: 5 bad packets on a 2-bit counter
    for (int k = 0; k < 5; k++) send_pkt(8'h05, 1, 1, -1);
    chk("sat_cnt", 32'(bus.err_cnt), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
